// File: rtl/pbtn_debounce.sv
// Six-channel pushbutton debouncer: per-bit polarity fix, 2-flop synchroniser,
// and an independent four-state qualify FSM with a stable-sample counter.
module pbtn_debounce #(
    parameter int         DB_COUNT = 500000,
    parameter logic [5:0] INV_MASK = 6'b000001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pbtn_in,
    output logic [5:0] db_btns,
    output logic [5:0] db_press
);

    localparam int CNT_W = $clog2(DB_COUNT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [5:0] sync_p0;
    logic [5:0] sync_p1;

    // Stage p0/p1: polarity-corrected raw inputs through a 2-flop synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pbtn_in ^ INV_MASK;
            sync_p1 <= sync_p0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < 6; i++) begin : g_ch
            state_t           state;
            state_t           state_nxt;
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_nxt;
            logic             s;
            logic             btn_q;
            logic             press_q;

            assign s = sync_p1[i];

            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                case (state)
                    IDLE: begin
                        if (s) begin
                            state_nxt = PRESS_WAIT;
                            cnt_nxt   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s)
                            state_nxt = IDLE;
                        else if (cnt == CNT_LAST)
                            state_nxt = PRESSED;
                        else
                            cnt_nxt = cnt + CNT_W'(1);
                    end
                    PRESSED: begin
                        if (!s) begin
                            state_nxt = RELEASE_WAIT;
                            cnt_nxt   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s)
                            state_nxt = PRESSED;
                        else if (cnt == CNT_LAST)
                            state_nxt = IDLE;
                        else
                            cnt_nxt = cnt + CNT_W'(1);
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end

            // Outputs are registered from the next state so the level moves on
            // the same edge the FSM accepts the change.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state   <= IDLE;
                    cnt     <= '0;
                    btn_q   <= 1'b0;
                    press_q <= 1'b0;
                end else begin
                    state   <= state_nxt;
                    cnt     <= cnt_nxt;
                    btn_q   <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
                    press_q <= (state == PRESS_WAIT) && (state_nxt == PRESSED);
                end
            end

            assign db_btns[i]  = btn_q;
            assign db_press[i] = press_q;
        end
    endgenerate

endmodule

// File: tb/tb_pbtn_debounce.sv
// Testbench for pbtn_debounce with DB_COUNT=4: directed scenarios plus random
// stimulus, all checked against a run-length reference model.
module tb_pbtn_debounce;

    localparam int         DB   = 4;
    localparam logic [5:0] INV  = 6'b000001;
    localparam logic [5:0] IDLE_IN = 6'b000001;

    logic       clk;
    logic       reset;
    logic [5:0] pbtn_in;
    logic [5:0] db_btns;
    logic [5:0] db_press;

    int tests_run;
    int tests_failed;

    // reference model state
    logic [5:0] m_s1, m_s2, m_db, m_press;
    logic [5:0] m_xs[$];

    pbtn_debounce #(.DB_COUNT(DB), .INV_MASK(INV)) dut (
        .clk     (clk),
        .reset   (reset),
        .pbtn_in (pbtn_in),
        .db_btns (db_btns),
        .db_press(db_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0;
        m_xs.delete();
    endtask

    // A bit changes once DB+1 consecutive synchronised samples disagree with it;
    // the synchronised sample seen at an edge is the raw input two edges earlier.
    task automatic model_edge();
        logic [5:0] x;
        bit all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        x    = m_s2;
        m_s2 = m_s1;
        m_s1 = pbtn_in ^ INV;
        m_xs.push_back(x);
        if (m_xs.size() > DB + 1) void'(m_xs.pop_front());
        m_press = '0;
        if (m_xs.size() == DB + 1) begin
            for (int b = 0; b < 6; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < m_xs.size(); k++)
                    if (m_xs[k][b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[b] = ~m_db[b];
                    if (m_db[b]) m_press[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pbtn_in = IDLE_IN;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if ({db_btns, db_press} !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset_state: got btns=%b press=%b, want 000000/000000", db_btns, db_press);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            tests_run++;
            if ({db_btns, db_press} !== {m_db, m_press}) begin
                tests_failed++;
                $display("FAIL reset_idle: got %b/%b, want %b/%b", db_btns, db_press, m_db, m_press);
            end
        end
    endtask

    task automatic test_press();
        pbtn_in = 6'b100001;
        for (int k = 0; k < 9; k++) begin
            step();
            tests_run++;
            if ({db_btns, db_press} !== {m_db, m_press}) begin
                tests_failed++;
                $display("FAIL press_model k=%0d: got %b/%b, want %b/%b", k, db_btns, db_press, m_db, m_press);
            end
            if (k == 5 || k == 6 || k == 7) begin
                tests_run++;
                if ((k == 5 && {db_btns, db_press} !== {6'b000000, 6'b000000}) ||
                    (k == 6 && {db_btns, db_press} !== {6'b100000, 6'b100000}) ||
                    (k == 7 && {db_btns, db_press} !== {6'b100000, 6'b000000})) begin
                    tests_failed++;
                    $display("FAIL press_latency k=%0d: got btns=%b press=%b", k, db_btns, db_press);
                end
            end
        end
        pbtn_in = IDLE_IN;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 5 || k == 6) begin
                tests_run++;
                if ((k == 5 && db_btns !== 6'b100000) || (k == 6 && db_btns !== 6'b000000) ||
                    db_press !== 6'b000000) begin
                    tests_failed++;
                    $display("FAIL release_latency k=%0d: got btns=%b press=%b", k, db_btns, db_press);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        for (int lvl = 0; lvl < 4; lvl++) begin
            pbtn_in[5] = (lvl % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                step();
                if (db_press[5]) presses++;
                tests_run++;
                if (db_btns !== 6'b000000) begin
                    tests_failed++;
                    $display("FAIL bounce_quiet: got btns=%b, want 000000", db_btns);
                end
            end
        end
        pbtn_in[5] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (db_press[5]) presses++;
            if (k == 5 || k == 6) begin
                tests_run++;
                if (db_btns[5] !== (k == 6)) begin
                    tests_failed++;
                    $display("FAIL bounce_rise k=%0d: got %b, want %b", k, db_btns[5], (k == 6));
                end
            end
        end
        tests_run++;
        if (presses != 1) begin
            tests_failed++;
            $display("FAIL bounce_pulses: got %0d, want 1", presses);
        end
    endtask

    task automatic test_release_glitch();
        pbtn_in[5] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        pbtn_in[5] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            tests_run++;
            if (db_btns[5] !== 1'b1 || db_press !== 6'b000000) begin
                tests_failed++;
                $display("FAIL glitch_hold k=%0d: got btns=%b press=%b, want btn5=1 press=0", k, db_btns, db_press);
            end
        end
        pbtn_in[5] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 5 || k == 6) begin
                tests_run++;
                if (db_btns[5] !== (k == 5)) begin
                    tests_failed++;
                    $display("FAIL glitch_release k=%0d: got %b, want %b", k, db_btns[5], (k == 5));
                end
            end
        end
    endtask

    task automatic test_active_low();
        pbtn_in[0] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k >= 5 && k <= 7) begin
                tests_run++;
                if (db_btns[0] !== (k >= 6) || db_press[0] !== (k == 6)) begin
                    tests_failed++;
                    $display("FAIL active_low_press k=%0d: got btn=%b press=%b", k, db_btns[0], db_press[0]);
                end
            end
        end
        pbtn_in[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 5 || k == 6) begin
                tests_run++;
                if (db_btns[0] !== (k == 5)) begin
                    tests_failed++;
                    $display("FAIL active_low_release k=%0d: got %b, want %b", k, db_btns[0], (k == 5));
                end
            end
        end
    endtask

    task automatic test_independence();
        pbtn_in[4] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) pbtn_in[1] = 1'b1;
            if (k == 6 || k == 7) begin
                tests_run++;
                if ((k == 6 && {db_btns, db_press} !== {6'b010000, 6'b010000}) ||
                    (k == 7 && {db_btns, db_press} !== {6'b010010, 6'b000010})) begin
                    tests_failed++;
                    $display("FAIL independence k=%0d: got btns=%b press=%b", k, db_btns, db_press);
                end
            end
        end
        pbtn_in = IDLE_IN;
        for (int k = 0; k < 10; k++) step();
        tests_run++;
        if (db_btns !== 6'b000000) begin
            tests_failed++;
            $display("FAIL independence_idle: got %b, want 000000", db_btns);
        end
    endtask

    task automatic test_reset_mid();
        pbtn_in = 6'b100001;
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({db_btns, db_press} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_async: got btns=%b press=%b, want 0/0", db_btns, db_press);
        end
        step();
        step();
        reset = 1'b0;
        for (int j = 0; j < 9; j++) begin
            step();
            tests_run++;
            if ({db_btns, db_press} !== {(j >= 6) ? 6'b100000 : 6'b000000,
                                          (j == 6) ? 6'b100000 : 6'b000000}) begin
                tests_failed++;
                $display("FAIL reset_requalify j=%0d: got btns=%b press=%b", j, db_btns, db_press);
            end
        end
        pbtn_in = IDLE_IN;
        for (int k = 0; k < 10; k++) step();
    endtask

    task automatic test_random();
        logic [5:0] flip;
        for (int n = 0; n < 3000; n++) begin
            flip = '0;
            for (int b = 0; b < 6; b++) flip[b] = ($urandom_range(0, 3) == 0);
            pbtn_in = pbtn_in ^ flip;
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            else reset = 1'b0;
            step();
            tests_run++;
            if ({db_btns, db_press} !== {m_db, m_press}) begin
                tests_failed++;
                $display("FAIL random n=%0d: got %b/%b, want %b/%b", n, db_btns, db_press, m_db, m_press);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        pbtn_in      = IDLE_IN;
        model_reset();
        test_reset();
        test_press();
        test_bounce();
        test_release_glitch();
        test_active_low();
        test_independence();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
